// File: rtl/y86_dmem_stage.sv
// Y86 data-memory stage: parametrised word memory with valid/ready handshakes,
// configurable read latency, optional byte addressing and a sticky halt.
module y86_dmem_stage #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned BYTE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valP,
    input  logic              imem_error,
    input  logic              instr_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] valM,
    output logic [2:0]        stat,
    output logic              halted
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SHIFT = (DATA_W >= 16) ? $clog2(DATA_W / 8) : 0;
    localparam int unsigned CNT_W = 2;

    localparam logic [CNT_W-1:0]  CNT_INIT = (RD_LAT >= 2) ? CNT_W'(RD_LAT - 2) : '0;
    localparam logic [DATA_W-1:0] LOW_MASK = DATA_W'((DATA_W / 8) - 1);
    localparam logic [DATA_W-1:0] DEPTH_W  = DATA_W'(DEPTH);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] IC_HALT   = 4'h1;
    localparam logic [3:0] IC_RMMOVQ = 4'h4;
    localparam logic [3:0] IC_MRMOVQ = 4'h5;
    localparam logic [3:0] IC_CALL   = 4'h8;
    localparam logic [3:0] IC_RET    = 4'h9;
    localparam logic [3:0] IC_PUSHQ  = 4'hA;
    localparam logic [3:0] IC_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic [DATA_W-1:0]  valm_q, valm_d;
    logic [2:0]         stat_q, stat_d;
    logic               halted_q, halted_d;

    logic               is_rd, is_wr;
    logic [DATA_W-1:0]  addr, wdata, widx;
    logic               dmem_err;
    logic [2:0]         stat_c;
    logic               accept, commit;
    logic [DATA_W-1:0]  rdata;

    logic [DATA_W-1:0]  mem [DEPTH];

    // Decode the access type, address, write data, error and status for the presented op.
    always_comb begin
        is_rd = 1'b0;
        is_wr = 1'b0;
        addr  = valE;
        wdata = valA;
        unique case (icode)
            IC_RMMOVQ, IC_PUSHQ: is_wr = 1'b1;
            IC_CALL: begin
                is_wr = 1'b1;
                wdata = valP;
            end
            IC_MRMOVQ: is_rd = 1'b1;
            IC_RET, IC_POPQ: begin
                is_rd = 1'b1;
                addr  = valA;
            end
            default: ;
        endcase

        widx = (BYTE_ADDR != 0) ? (addr >> SHIFT) : addr;
        // Full-width compare: high address bits never wrap into the array.
        dmem_err = (is_rd || is_wr) &&
                   ((widx >= DEPTH_W) || ((BYTE_ADDR != 0) && ((addr & LOW_MASK) != '0)));

        if (imem_error)        stat_c = STAT_ADR;
        else if (!instr_valid) stat_c = STAT_INS;
        else if (dmem_err)     stat_c = STAT_ADR;
        else if (icode == IC_HALT) stat_c = STAT_HLT;
        else                   stat_c = STAT_AOK;

        accept = in_valid && in_ready_q;
        commit = accept && is_wr && !dmem_err && !imem_error && instr_valid;
        rdata  = mem[widx[AW-1:0]];
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valm_d   = valm_q;
        stat_d   = stat_q;
        halted_d = halted_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    stat_d = stat_c;
                    valm_d = (is_rd && (stat_c == STAT_AOK)) ? rdata : '0;
                    if (is_rd && (RD_LAT > 1)) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    if (stat_q != STAT_AOK) halted_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        out_valid_d = (state_d == S_RESP);
        in_ready_d  = (state_d == S_IDLE) && !halted_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            valm_q      <= '0;
            stat_q      <= STAT_AOK;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            valm_q      <= valm_d;
            stat_q      <= stat_d;
            halted_q    <= halted_d;
        end
    end

    // Memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit) mem[widx[AW-1:0]] <= wdata;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign valM      = valm_q;
    assign stat      = stat_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_y86_dmem_stage.sv
// Scoreboard bench for y86_dmem_stage: three instances (RD_LAT 1/3/4, one byte-addressed).
module tb_y86_dmem_stage;

    localparam int NDUT = 3;
    localparam int K_OV = 0, K_IR = 1, K_HALT = 2, K_STAT = 3, K_VALM = 4;

    typedef struct {
        logic [63:0] valm;
        logic [2:0]  stat;
    } resp_t;

    typedef struct {
        int          at;
        int          d;
        int          kind;
        logic [63:0] exp;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst_n      [NDUT];
    logic        in_valid   [NDUT];
    logic        in_ready   [NDUT];
    logic [3:0]  icode      [NDUT];
    logic [63:0] valA       [NDUT];
    logic [63:0] valE       [NDUT];
    logic [63:0] valP       [NDUT];
    logic        imem_error [NDUT];
    logic        instr_valid[NDUT];
    logic        out_valid  [NDUT];
    logic        out_ready  [NDUT];
    logic [63:0] valM       [NDUT];
    logic [2:0]  stat       [NDUT];
    logic        halted     [NDUT];

    resp_t resp_q [NDUT][$];
    chk_t  chk_q[$];
    int    cyc = 0;
    int    n_vec = 0;
    int    n_bad = 0;
    bit    done = 1'b0;
    bit    final_done = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        y86_dmem_stage #(
            .DATA_W   (64),
            .DEPTH    (4096),
            .RD_LAT   ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
            .BYTE_ADDR((g == 1) ? 1 : 0)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .icode      (icode[g]),
            .valA       (valA[g]),
            .valE       (valE[g]),
            .valP       (valP[g]),
            .imem_error (imem_error[g]),
            .instr_valid(instr_valid[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .valM       (valM[g]),
            .stat       (stat[g]),
            .halted     (halted[g])
        );
    end

    function automatic logic [63:0] get_act(input int d, input int kind);
        case (kind)
            K_OV:    return 64'(out_valid[d]);
            K_IR:    return 64'(in_ready[d]);
            K_HALT:  return 64'(halted[d]);
            K_STAT:  return 64'(stat[d]);
            default: return valM[d];
        endcase
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            K_OV:    return "out_valid";
            K_IR:    return "in_ready";
            K_HALT:  return "halted";
            K_STAT:  return "stat";
            default: return "valM";
        endcase
    endfunction

    // Monitor: compares every presented response and every scheduled point check.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (out_valid[d]) begin
                n_vec++;
                if (resp_q[d].size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_resp dut%0d: got valM=%0h stat=%0d, required no response",
                             d, valM[d], stat[d]);
                end else begin
                    if (valM[d] !== resp_q[d][0].valm || stat[d] !== resp_q[d][0].stat) begin
                        n_bad++;
                        $display("FAIL resp dut%0d cyc%0d: got valM=%0h stat=%0d, required valM=%0h stat=%0d",
                                 d, cyc, valM[d], stat[d], resp_q[d][0].valm, resp_q[d][0].stat);
                    end
                    if (out_ready[d]) void'(resp_q[d].pop_front());
                end
            end
        end
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].at <= cyc) begin
                logic [63:0] act;
                act = get_act(chk_q[i].d, chk_q[i].kind);
                n_vec++;
                if (act !== chk_q[i].exp) begin
                    n_bad++;
                    $display("FAIL %s dut%0d cyc%0d: got %0h, required %0h",
                             kname(chk_q[i].kind), chk_q[i].d, cyc, act, chk_q[i].exp);
                end
                chk_q.delete(i);
            end
        end
        if (done && !final_done) begin
            for (int d = 0; d < NDUT; d++) begin
                n_vec++;
                if (resp_q[d].size() != 0) begin
                    n_bad++;
                    $display("FAIL missing_resp dut%0d: got %0d outstanding, required 0", d, resp_q[d].size());
                end
            end
            final_done = 1'b1;
        end
        cyc++;
    end

    // Schedule a point check k negedges from now.
    task automatic expect_at(input int d, input int k, input int kind, input logic [63:0] e);
        chk_q.push_back('{cyc + k, d, kind, e});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rst(input int d);
        rst_n[d] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[d] = 1'b1;
    endtask

    // Present one op, wait (bounded) for acceptance; returns at accept edge + 1.
    task automatic issue(input int d, input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                         input logic [63:0] p, input logic ie, input logic iv,
                         input logic [63:0] xm, input logic [2:0] xs, input bit track);
        int n;
        icode[d] = ic; valA[d] = a; valE[d] = e; valP[d] = p;
        imem_error[d] = ie; instr_valid[d] = iv;
        in_valid[d] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready[d]) break;
            n++;
            if (n > 50) begin
                expect_at(d, 1, K_IR, 64'd1);
                in_valid[d] = 1'b0;
                idle(1);
                return;
            end
        end
        if (track) resp_q[d].push_back('{xm, xs});
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic wr(input int d, input logic [3:0] ic, input logic [63:0] ad, input logic [63:0] data);
        issue(d, ic, data, ad, 64'd0, 1'b0, 1'b1, 64'd0, 3'd1, 1'b1);
    endtask

    task automatic rd(input int d, input logic [63:0] ad, input logic [63:0] xm);
        issue(d, 4'h5, 64'd0, ad, 64'd0, 1'b0, 1'b1, xm, 3'd1, 1'b1);
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst_n[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b1;
            icode[d] = 4'h0; valA[d] = '0; valE[d] = '0; valP[d] = '0;
            imem_error[d] = 1'b0; instr_valid[d] = 1'b1;
        end
        idle(2);
        // Reset state
        for (int d = 0; d < NDUT; d++) begin
            expect_at(d, 0, K_OV, 64'd0);
            expect_at(d, 0, K_VALM, 64'd0);
            expect_at(d, 0, K_STAT, 64'd1);
            expect_at(d, 0, K_HALT, 64'd0);
            expect_at(d, 0, K_IR, 64'd1);
        end
        idle(1);
        for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b1;
        idle(1);

        // Write then read, RD_LAT=1
        wr(0, 4'h4, 64'd16, 64'hDEADBEEF);
        expect_at(0, 0, K_OV, 64'd1);
        idle(2);
        rd(0, 64'd16, 64'hDEADBEEF);
        expect_at(0, 0, K_OV, 64'd1);
        idle(2);

        // Write then read, RD_LAT=3 byte-addressed (byte 16 = word 2)
        wr(1, 4'h4, 64'd16, 64'hDEADBEEF);
        expect_at(1, 0, K_OV, 64'd1);
        idle(2);
        rd(1, 64'd16, 64'hDEADBEEF);
        expect_at(1, 1, K_OV, 64'd0);
        expect_at(1, 2, K_OV, 64'd1);
        idle(5);
        wr(1, 4'h4, 64'h18, 64'h0123456789ABCDEF);
        rd(1, 64'h18, 64'h0123456789ABCDEF);
        // call writes valP, popq reads via valA
        issue(1, 4'h8, 64'd0, 64'h20, 64'h0000_0000_0000_0777, 1'b0, 1'b1, 64'd0, 3'd1, 1'b1);
        issue(1, 4'hB, 64'h20, 64'd0, 64'd0, 1'b0, 1'b1, 64'h777, 3'd1, 1'b1);
        // Misaligned read
        issue(1, 4'h5, 64'd0, 64'h13, 64'd0, 1'b0, 1'b1, 64'd0, 3'd3, 1'b1);
        idle(6);
        expect_at(1, 0, K_HALT, 64'd1);
        expect_at(1, 0, K_IR, 64'd0);
        idle(1);

        // Write then read, RD_LAT=4
        wr(2, 4'h4, 64'd16, 64'h1234);
        idle(2);
        rd(2, 64'd16, 64'h1234);
        expect_at(2, 2, K_OV, 64'd0);
        expect_at(2, 3, K_OV, 64'd1);
        idle(6);

        // Back-pressure on a read response
        wr(0, 4'hA, 64'd100, 64'h55);
        idle(2);
        out_ready[0] = 1'b0;
        rd(0, 64'd100, 64'h55);
        for (int k = 0; k < 5; k++) begin
            expect_at(0, k, K_OV, 64'd1);
            expect_at(0, k, K_IR, 64'd0);
        end
        idle(5);
        out_ready[0] = 1'b1;
        expect_at(0, 0, K_OV, 64'd1);
        expect_at(0, 1, K_OV, 64'd0);
        expect_at(0, 1, K_IR, 64'd1);
        idle(3);

        // Out of range writes leave memory intact and halt
        wr(0, 4'h4, 64'd4095, 64'hAAAA);
        wr(0, 4'hA, 64'd0, 64'hBBBB);
        issue(0, 4'hA, 64'h1111, 64'd4096, 64'd0, 1'b0, 1'b1, 64'd0, 3'd3, 1'b1);
        expect_at(0, 0, K_HALT, 64'd0);
        expect_at(0, 1, K_HALT, 64'd1);
        expect_at(0, 1, K_IR, 64'd0);
        idle(3);
        expect_at(0, 0, K_IR, 64'd0);
        idle(1);
        rst(0);
        issue(0, 4'h4, 64'h2222, 64'h0000_0001_0000_0FFF, 64'd0, 1'b0, 1'b1, 64'd0, 3'd3, 1'b1);
        idle(3);
        rst(0);
        rd(0, 64'd4095, 64'hAAAA);
        rd(0, 64'd0, 64'hBBBB);
        idle(3);

        // Status priority
        issue(2, 4'h1, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 3'd3, 1'b1);
        idle(3);
        rst(2);
        issue(2, 4'h0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 3'd4, 1'b1);
        idle(3);
        rst(2);
        issue(2, 4'h1, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 3'd2, 1'b1);
        expect_at(2, 1, K_HALT, 64'd1);
        expect_at(2, 1, K_IR, 64'd0);
        idle(3);
        rst(2);

        // Reset mid-read: response dropped, earlier write retained
        wr(2, 4'h4, 64'd40, 64'hCAFE);
        idle(2);
        issue(2, 4'h5, 64'd0, 64'd40, 64'd0, 1'b0, 1'b1, 64'd0, 3'd1, 1'b0);
        @(posedge clk);
        #1;
        rst_n[2] = 1'b0;
        expect_at(2, 0, K_OV, 64'd0);
        expect_at(2, 0, K_STAT, 64'd1);
        expect_at(2, 0, K_HALT, 64'd0);
        expect_at(2, 0, K_IR, 64'd1);
        idle(1);
        rst_n[2] = 1'b1;
        idle(6);
        rd(2, 64'd40, 64'hCAFE);

        idle(10);
        done = 1'b1;
        for (int i = 0; i < 20 && !final_done; i++) @(posedge clk);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
